// File: rtl/cpu6502_irq_timer_pkg.sv
// Shared register map, bit positions and reset values for the 6502 IRQ timer.
package cpu6502_irq_timer_pkg;

  typedef enum logic [2:0] {
    TMR_CTRL     = 3'd0,
    TMR_STATUS   = 3'd1,
    TMR_RELOAD_L = 3'd2,
    TMR_RELOAD_H = 3'd3,
    TMR_COUNT_L  = 3'd4,
    TMR_COUNT_H  = 3'd5,
    TMR_PRESCALE = 3'd6,
    TMR_WDOG     = 3'd7
  } tmrReg_e;

  localparam int unsigned CTRL_RUN       = 0;
  localparam int unsigned CTRL_PERIODIC  = 1;
  localparam int unsigned CTRL_IRQEN     = 2;
  localparam int unsigned STATUS_EXPIRED = 0;
  localparam int unsigned STATUS_RUN     = 1;

  localparam logic [7:0]  REG_RESET   = '0;
  localparam logic [15:0] COUNT_RESET = '0;

endpackage

// File: rtl/cpu6502_tick_prescaler.sv
// 8-bit prescaler: emits one tick every (divisor+1) enabled cycles while run is high.
module cpu6502_tick_prescaler
  import cpu6502_irq_timer_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       run,
  input  logic       load,
  input  logic [7:0] divisor,
  output logic       tick
);

  logic [7:0] pre;

  assign tick = enable && run && (pre == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pre <= REG_RESET;
    end else if (enable) begin
      if (load) begin
        pre <= divisor;
      end else if (run) begin
        pre <= (pre == '0) ? divisor : pre - 8'd1;
      end
    end
  end

endmodule

// File: rtl/cpu6502_irq_timer.sv
// Memory-mapped timer/interrupt source for the 6502 bus, registers at BASE_ADDR..BASE_ADDR+7.
// Optional watchdog NMI source enabled by defining CPU6502_IRQ_TIMER_WATCHDOG_EN.
module cpu6502_irq_timer
  import cpu6502_irq_timer_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR        = 16'hD000,
  parameter int unsigned NMI_PULSE_CYCLES = 2,
  parameter logic [15:0] WDOG_TIMEOUT     = 16'h0FFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] address,
  input  logic [7:0]  dataIn,
  input  logic        dataWriteEnable,
  output logic [7:0]  dataOut,
  output logic        selected,
  output logic        nIRQ,
  output logic        nNMI
);

  localparam logic [3:0] NMI_LEN = 4'(NMI_PULSE_CYCLES);

  logic        run, periodic, irqEn, expired;
  logic [15:0] reload, count;
  logic [7:0]  prescale, snapshot;
  logic        nIrqReg;
  logic        wdogArmed;
  logic        tick, timerTick, expire, startLoad, statusClr;
  logic        busWr, busRd;
  tmrReg_e     regSel;

  assign selected = (address[15:3] == BASE_ADDR[15:3]);
  assign regSel   = tmrReg_e'(address[2:0]);
  assign busWr    = enable && selected && dataWriteEnable;
  assign busRd    = enable && selected && !dataWriteEnable;

  assign startLoad = busWr && (regSel == TMR_CTRL) && dataIn[CTRL_RUN] && !run;
  assign timerTick = tick && run;
  assign expire    = timerTick && (count == '0);
  assign statusClr = (busRd && (regSel == TMR_STATUS)) ||
                     (busWr && (regSel == TMR_STATUS) && dataIn[STATUS_EXPIRED]);

  cpu6502_tick_prescaler uPrescaler (
    .clock   (clock),
    .reset   (reset),
    .enable  (enable),
    .run     (run || wdogArmed),
    .load    (startLoad),
    .divisor (prescale),
    .tick    (tick)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      run      <= 1'b0;
      periodic <= 1'b0;
      irqEn    <= 1'b0;
      expired  <= 1'b0;
      reload   <= COUNT_RESET;
      count    <= COUNT_RESET;
      prescale <= REG_RESET;
      snapshot <= REG_RESET;
      nIrqReg  <= 1'b1;
    end else if (enable) begin
      nIrqReg <= ~(expired & irqEn);

      if (timerTick) begin
        if (count == '0) begin
          if (periodic) count <= reload;
          else          run   <= 1'b0;
        end else begin
          count <= count - 16'd1;
        end
      end

      // Expiry is applied after the clear so a coincident clear loses.
      if (statusClr) expired <= 1'b0;
      if (expire)    expired <= 1'b1;

      if (busWr) begin
        case (regSel)
          TMR_CTRL: begin
            periodic <= dataIn[CTRL_PERIODIC];
            irqEn    <= dataIn[CTRL_IRQEN];
            if (startLoad) begin
              run   <= 1'b1;
              count <= reload;
            end else if (!dataIn[CTRL_RUN]) begin
              run <= 1'b0;
            end
          end
          TMR_RELOAD_L: reload[7:0]  <= dataIn;
          TMR_RELOAD_H: reload[15:8] <= dataIn;
          TMR_PRESCALE: prescale     <= dataIn;
          default: ;
        endcase
      end

      if (busRd && (regSel == TMR_COUNT_L)) snapshot <= count[15:8];
    end
  end

  assign nIRQ = nIrqReg;

`ifdef CPU6502_IRQ_TIMER_WATCHDOG_EN
  logic [15:0] wdog;
  logic [3:0]  nmiCnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wdogArmed <= 1'b0;
      wdog      <= COUNT_RESET;
      nmiCnt    <= '0;
    end else if (enable) begin
      if (nmiCnt != '0) nmiCnt <= nmiCnt - 4'd1;
      if (busWr && (regSel == TMR_WDOG)) begin
        wdogArmed <= 1'b1;
        wdog      <= WDOG_TIMEOUT;
      end else if (wdogArmed && tick) begin
        if (wdog == '0) begin
          wdog   <= WDOG_TIMEOUT;
          nmiCnt <= NMI_LEN;
        end else begin
          wdog <= wdog - 16'd1;
        end
      end
    end
  end

  assign nNMI = (nmiCnt == '0);
`else
  logic unusedWdogCfg;
  assign unusedWdogCfg = ^{WDOG_TIMEOUT, NMI_LEN};
  assign wdogArmed     = 1'b0;
  assign nNMI          = 1'b1;
`endif

  always_comb begin
    dataOut = '0;
    if (selected) begin
      case (regSel)
        TMR_CTRL:     dataOut = {5'b0, irqEn, periodic, run};
        TMR_STATUS:   dataOut = {6'b0, run, expired};
        TMR_RELOAD_L: dataOut = reload[7:0];
        TMR_RELOAD_H: dataOut = reload[15:8];
        TMR_COUNT_L:  dataOut = count[7:0];
        TMR_COUNT_H:  dataOut = snapshot;
        TMR_PRESCALE: dataOut = prescale;
        TMR_WDOG:     dataOut = {7'b0, wdogArmed};
        default:      dataOut = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu6502_irq_timer.sv
// Scoreboard bench for cpu6502_irq_timer: directed bus cycles push expectations, a negedge monitor checks them.
module tb_cpu6502_irq_timer;

  localparam logic [15:0] BASE = 16'hD000;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] address;
  logic [7:0]  dataIn;
  logic        dataWriteEnable;
  logic [7:0]  dataOut;
  logic        selected;
  logic        nIRQ;
  logic        nNMI;

  always #5 clock = ~clock;

  cpu6502_irq_timer #(
    .BASE_ADDR        (BASE),
    .NMI_PULSE_CYCLES (2),
    .WDOG_TIMEOUT     (16'h0004)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .enable          (enable),
    .address         (address),
    .dataIn          (dataIn),
    .dataWriteEnable (dataWriteEnable),
    .dataOut         (dataOut),
    .selected        (selected),
    .nIRQ            (nIRQ),
    .nNMI            (nNMI)
  );

  // kind: 0 dataOut, 1 nIRQ, 2 nNMI, 3 selected
  typedef struct {
    string      name;
    int         kind;
    logic [7:0] exp;
  } chk_t;

  chk_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  chk_t       cur;
  logic [7:0] act;

  always @(negedge clock) begin
    while (sb.size() > 0) begin
      cur = sb.pop_front();
      case (cur.kind)
        0:       act = dataOut;
        1:       act = {7'b0, nIRQ};
        2:       act = {7'b0, nNMI};
        default: act = {7'b0, selected};
      endcase
      vectors++;
      if (act !== cur.exp) begin
        miscompares++;
        $display("FAIL %s: got %02h expected %02h", cur.name, act, cur.exp);
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic want(input string nm, input int k, input logic [7:0] v);
    chk_t e;
    e.name = nm;
    e.kind = k;
    e.exp  = v;
    sb.push_back(e);
  endtask

  task automatic idle();
    address         = 16'h0000;
    dataWriteEnable = 1'b0;
    dataIn          = 8'h00;
  endtask

  task automatic wr(input logic [2:0] off, input logic [7:0] d);
    address         = BASE + {13'b0, off};
    dataIn          = d;
    dataWriteEnable = 1'b1;
    cyc();
    idle();
  endtask

  task automatic rd(input logic [2:0] off, input logic [7:0] v, input string nm);
    address         = BASE + {13'b0, off};
    dataWriteEnable = 1'b0;
    want(nm, 0, v);
    cyc();
    idle();
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b1;
    idle();
    cyc(2);
    reset = 1'b0;

    // Reset state and decode
    want("nirq_rst", 1, 8'h01);
    want("nnmi_rst", 2, 8'h01);
    address = 16'hCFFF;
    want("sel_below", 3, 8'h00);
    cyc();
    address = BASE;
    want("sel_base", 3, 8'h01);
    cyc();
    idle();
    for (int i = 0; i < 8; i++) rd(3'(i), 8'h00, $sformatf("rst_reg%0d", i));
    enable = 1'b0;
    wr(3'd0, 8'h07);
    enable = 1'b1;
    rd(3'd0, 8'h00, "ctrl_gated_wr");

    // One-shot, RELOAD=3, PRESCALE=0
    wr(3'd2, 8'h03);
    wr(3'd3, 8'h00);
    wr(3'd6, 8'h00);
    wr(3'd0, 8'h05);
    cyc(3);
    want("os_nirq_pre", 1, 8'h01);
    cyc();
    want("os_nirq_lag", 1, 8'h01);
    cyc();
    want("os_nirq_low", 1, 8'h00);
    rd(3'd1, 8'h01, "os_status");
    want("os_nirq_hold", 1, 8'h00);
    cyc();
    want("os_nirq_clr", 1, 8'h01);
    rd(3'd0, 8'h04, "os_ctrl_stopped");

    // Periodic, RELOAD=2, PRESCALE=1: expiry every 6 enabled cycles
    wr(3'd2, 8'h02);
    wr(3'd6, 8'h01);
    wr(3'd0, 8'h07);
    cyc(5);
    rd(3'd1, 8'h02, "per_rdclr_vs_exp");
    rd(3'd1, 8'h03, "per_exp_wins_rd");
    rd(3'd1, 8'h02, "per_cleared");
    for (int i = 0; i < 3; i++) begin
      enable = 1'b0;
      cyc();
      enable = 1'b1;
      cyc();
    end
    enable = 1'b0;
    rd(3'd1, 8'h02, "per_gated_rd");
    enable = 1'b1;
    rd(3'd1, 8'h02, "per_rdclr_vs_exp2");
    rd(3'd1, 8'h03, "per_exp_wins_rd2");
    cyc(4);
    wr(3'd1, 8'h01);
    rd(3'd1, 8'h03, "per_exp_wins_wr");
    want("per_nirq_low", 1, 8'h00);
    rd(3'd4, 8'h02, "per_count_l_max");
    rd(3'd5, 8'h00, "per_count_h");
    wr(3'd0, 8'h06);
    rd(3'd0, 8'h06, "per_ctrl_stop");

    // COUNT snapshot across the 0x0100 -> 0x00FF step
    wr(3'd2, 8'h00);
    wr(3'd3, 8'h01);
    wr(3'd6, 8'h00);
    wr(3'd0, 8'h01);
    rd(3'd4, 8'h00, "snap_count_l");
    rd(3'd5, 8'h01, "snap_count_h");
    rd(3'd4, 8'hFE, "snap_count_l_next");
    wr(3'd0, 8'h00);

`ifdef CPU6502_IRQ_TIMER_WATCHDOG_EN
    wr(3'd7, 8'hAA);
    for (int i = 1; i <= 7; i++) begin
      cyc();
      want($sformatf("wd_nnmi_c%0d", i), 2, (i == 5 || i == 6) ? 8'h00 : 8'h01);
    end
    rd(3'd7, 8'h01, "wd_armed");
    for (int k = 0; k < 4; k++) begin
      want("wd_kick_nnmi", 2, 8'h01);
      wr(3'd7, 8'h00);
      want("wd_kick_nnmi", 2, 8'h01);
      cyc();
      want("wd_kick_nnmi", 2, 8'h01);
      cyc();
    end
`else
    rd(3'd7, 8'h00, "wd_off_rd");
    wr(3'd7, 8'hFF);
    for (int i = 1; i <= 6; i++) begin
      cyc();
      want("wd_off_nnmi", 2, 8'h01);
    end
    rd(3'd7, 8'h00, "wd_off_rd2");
`endif

    // Async reset while interrupt is asserted
    wr(3'd2, 8'h00);
    wr(3'd3, 8'h00);
    wr(3'd0, 8'h05);
    cyc(2);
    want("ar_nirq_low", 1, 8'h00);
    cyc();
    reset = 1'b1;
    #1;
    want("ar_nirq_async", 1, 8'h01);
    want("ar_nnmi_async", 2, 8'h01);
    cyc();
    reset = 1'b0;
    rd(3'd0, 8'h00, "ar_ctrl");
    rd(3'd1, 8'h00, "ar_status");

    cyc(3);
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      miscompares += sb.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
